// File: rtl/j1_dbus_wb_bridge.sv
// Bridges the J1 core data bus (single-cycle read/write strobes) onto a classic
// Wishbone master port, holding the core via stall until the slave terminates.
module j1_dbus_wb_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dbus_adr,
    input  logic        dbus_re,
    input  logic        dbus_we,
    input  logic [15:0] dbus_dat_m,
    output logic [15:0] dbus_dat_s,
    output logic        stall,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic [1:0]  wb_sel_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        err_o,
    input  logic        err_clr,
    output logic        dbg_state
);

    // Handshake: the core issues a one-cycle re/we strobe while IDLE; the bridge
    // then holds stall high in BUS until ack, err or timeout terminates the cycle,
    // and the core only advances in a cycle where stall is low.
    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [15:0] adr_q;
    logic [15:0] dat_q;
    logic [15:0] rd_q;
    logic        we_q;

    logic        in_bus;
    logic        req;
    logic        timeout_hit;
    logic        term;
    logic        rd_done;
    logic        err_set;
    logic [15:0] rd_value;
    logic        unused_adr_msb;

    // Word address to byte address drops the top bit of the core address.
    assign unused_adr_msb = dbus_adr[15];

    assign in_bus      = (state == BUS);
    assign req         = dbus_re | dbus_we;
    assign timeout_hit = (cnt == CNT_LAST);
    assign term        = in_bus & (wb_ack_i | wb_err_i | timeout_hit);
    assign rd_done     = term & ~we_q;
    assign rd_value    = wb_ack_i ? wb_dat_i : 16'h0000;
    // ack wins over a simultaneous err, so only an unacknowledged end flags.
    assign err_set     = in_bus & ~wb_ack_i & (wb_err_i | timeout_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = BUS;
                    cnt_next   = 8'd0;
                end
            end
            BUS: begin
                if (term) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // A write strobe takes priority when both strobes arrive together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adr_q <= 16'h0000;
            dat_q <= 16'h0000;
            we_q  <= 1'b0;
        end else if (!in_bus && req) begin
            adr_q <= {dbus_adr[14:0], 1'b0};
            dat_q <= dbus_dat_m;
            we_q  <= dbus_we;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= 16'h0000;
        end else if (rd_done) begin
            rd_q <= rd_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_o <= 1'b0;
        end else if (err_set) begin
            err_o <= 1'b1;
        end else if (err_clr) begin
            err_o <= 1'b0;
        end
    end

    // Read data bypasses the register in the terminating cycle so a zero-wait
    // ack releases the core with valid data and no stall.
    assign dbus_dat_s = rd_done ? rd_value : rd_q;
    assign stall      = in_bus & ~term;
    assign wb_cyc_o   = in_bus;
    assign wb_stb_o   = in_bus;
    assign wb_sel_o   = in_bus ? 2'b11 : 2'b00;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_j1_dbus_wb_bridge.sv
// Self-checking bench for j1_dbus_wb_bridge with TIMEOUT=4: directed cases for
// zero-wait, wait-state, timeout, error, reset abort and a short random run.
module tb_j1_dbus_wb_bridge;

    localparam int TIMEOUT = 4;

    // kinds of termination driven by the slave model
    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_NONE   = 2;
    localparam int K_ACKERR = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] dbus_adr = '0;
    logic        dbus_re = 1'b0;
    logic        dbus_we = 1'b0;
    logic [15:0] dbus_dat_m = '0;
    logic [15:0] dbus_dat_s;
    logic        stall;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_o;
    logic [15:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        err_o;
    logic        err_clr = 1'b0;
    logic        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_rd = 16'h0000;
    logic        err_exp = 1'b0;
    logic        clr_on_term = 1'b0;

    j1_dbus_wb_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .dbus_adr   (dbus_adr),
        .dbus_re    (dbus_re),
        .dbus_we    (dbus_we),
        .dbus_dat_m (dbus_dat_m),
        .dbus_dat_s (dbus_dat_s),
        .stall      (stall),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .err_o      (err_o),
        .err_clr    (err_clr),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one access starting at a negedge in IDLE; returns at the negedge
    // after termination with the bridge back in IDLE.
    task automatic run_access(input logic [15:0] adr, input logic a_re, input logic a_we,
                              input logic [15:0] wdat, input int waits, input int kind,
                              input logic [15:0] rdat);
        int n;
        int stalls;
        logic is_read;
        logic [15:0] exp_rd;
        is_read = a_re & ~a_we;
        check_eq("idle_state", dbg_state, 0);
        check_eq("idle_cyc", wb_cyc_o, 0);
        dbus_adr   = adr;
        dbus_re    = a_re;
        dbus_we    = a_we;
        dbus_dat_m = wdat;
        if (is_read) exp_q.push_back((kind == K_ACK || kind == K_ACKERR) ? rdat : 16'h0000);
        @(negedge clk);
        dbus_re = 1'b0;
        dbus_we = 1'b0;
        dbus_adr = 16'($urandom_range(0, 16'hffff));
        #1;
        check_eq("bus_cyc", {wb_cyc_o, wb_stb_o}, 2'b11);
        check_eq("bus_sel", wb_sel_o, 2'b11);
        check_eq("bus_adr", wb_adr_o, {adr[14:0], 1'b0});
        check_eq("bus_we", wb_we_o, a_we);
        if (a_we) check_eq("bus_wdat", wb_dat_o, wdat);
        n = 0;
        stalls = 0;
        forever begin
            if (n == waits && kind != K_NONE) begin
                wb_ack_i = (kind == K_ACK || kind == K_ACKERR);
                wb_err_i = (kind == K_ERR || kind == K_ACKERR);
                wb_dat_i = rdat;
                err_clr  = clr_on_term;
            end
            #1;
            if (!stall) break;
            stalls++;
            if (n > 300) begin
                check_eq("bus_bound", stall, 0);
                break;
            end
            @(negedge clk);
            n++;
        end
        check_eq("term_cycle", n, (kind == K_NONE) ? TIMEOUT - 1 : waits);
        check_eq("stall_cycles", stalls, n);
        if (is_read) begin
            if (exp_q.size() == 0) begin
                check_eq("queue_underflow", 0, 1);
            end else begin
                exp_rd = exp_q.pop_front();
                check_eq("rd_comb", dbus_dat_s, exp_rd);
                last_rd = exp_rd;
            end
        end else begin
            check_eq("wr_dat_s", dbus_dat_s, last_rd);
        end
        if (kind == K_ERR || kind == K_NONE) err_exp = 1'b1;
        else if (clr_on_term) err_exp = 1'b0;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        err_clr  = 1'b0;
        wb_dat_i = 16'($urandom_range(0, 16'hffff));
        #1;
        check_eq("post_cyc", wb_cyc_o, 0);
        check_eq("post_stall", stall, 0);
        check_eq("rd_held", dbus_dat_s, last_rd);
        check_eq("err_flag", err_o, err_exp);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b0;
        #1;
        check_eq("err_cleared", err_o, 0);
    endtask

    initial begin
        #2;
        check_eq("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        check_eq("rst_adr", wb_adr_o, 0);
        check_eq("rst_dat", wb_dat_o, 0);
        check_eq("rst_sel", wb_sel_o, 0);
        check_eq("rst_dat_s", dbus_dat_s, 0);
        check_eq("rst_err_stall", {err_o, stall}, 2'b00);
        check_eq("rst_state", dbg_state, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_access(16'h0012, 1'b1, 1'b0, 16'h0000, 0, K_ACK, 16'hBEEF);
        run_access(16'h0040, 1'b0, 1'b1, 16'h1234, 3, K_ACK, 16'h5555);
        run_access(16'h0033, 1'b1, 1'b0, 16'h0000, 0, K_NONE, 16'hAAAA);
        pulse_err_clr();
        run_access(16'h8007, 1'b1, 1'b0, 16'h0000, 1, K_ERR, 16'hFFFF);
        pulse_err_clr();
        run_access(16'h0100, 1'b1, 1'b1, 16'h4321, 1, K_ACK, 16'h7777);
        run_access(16'h0101, 1'b1, 1'b0, 16'h0000, 2, K_ACKERR, 16'h6A6A);
        // clear and set in the same cycle: set wins
        clr_on_term = 1'b1;
        run_access(16'h0102, 1'b1, 1'b0, 16'h0000, 0, K_ERR, 16'h0F0F);
        clr_on_term = 1'b0;
        pulse_err_clr();

        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            logic        w;
            int          k;
            a = 16'($urandom_range(0, 16'hffff));
            w = 1'($urandom_range(0, 1));
            k = ($urandom_range(0, 3) == 0) ? K_ERR : K_ACK;
            run_access(a, ~w, w, 16'($urandom_range(0, 16'hffff)),
                       $urandom_range(0, 2), k, 16'($urandom_range(0, 16'hffff)));
        end
        if (err_exp) pulse_err_clr();

        // reset during the wait of a read
        dbus_adr = 16'h0077;
        dbus_re  = 1'b1;
        @(negedge clk);
        dbus_re = 1'b0;
        #1;
        check_eq("abort_cyc_before", wb_cyc_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
        check_eq("abort_err", err_o, 0);
        check_eq("abort_stall", stall, 0);
        check_eq("abort_dat_s", dbus_dat_s, 0);
        last_rd = 16'h0000;
        err_exp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_access(16'h0078, 1'b1, 1'b0, 16'h0000, 1, K_ACK, 16'hC0DE);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
